// File: rtl/exe_unit_w2.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative SHL/MUL,
// result and status held in DONE until the consumer takes them.
module exe_unit_w2 #(
   parameter int M = 8,
   parameter int N = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_oper,
   input  logic [M-1:0] i_argA,
   input  logic [M-1:0] i_argB,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [M-1:0] o_result,
   output logic [3:0]   o_status
);

   localparam int SW = $clog2(M);
   localparam int CW = $clog2(M + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [N-1:0] OP_ADD = N'(0);
   localparam logic [N-1:0] OP_SUB = N'(1);
   localparam logic [N-1:0] OP_AND = N'(2);
   localparam logic [N-1:0] OP_OR  = N'(3);
   localparam logic [N-1:0] OP_XOR = N'(4);
   localparam logic [N-1:0] OP_SHL = N'(5);
   localparam logic [N-1:0] OP_MUL = N'(6);

   logic [1:0]     state_q, state_d;
   logic [N-1:0]   op_q, op_d;
   logic [2*M-1:0] work_q, work_d;   // shifted operand (SHL) or multiplicand (MUL)
   logic [M-1:0]   mplr_q, mplr_d;
   logic [2*M-1:0] acc_q, acc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sovf_q, sovf_d;
   logic [M-1:0]   result_q, result_d;
   logic [3:0]     status_q, status_d;

   logic [M-1:0]   sum, diff, sc_res, fin_res;
   logic [SW-1:0]  shamt;
   logic           sc_ovf, sc_ill, sc_multi, fin_ovf;
   logic [2*M-1:0] acc_nx;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sovf_d   = sovf_q;
      result_d = result_q;
      status_d = status_q;
      sc_res   = '0;
      sc_ovf   = 1'b0;
      sc_ill   = 1'b0;
      sc_multi = 1'b0;
      fin_res  = '0;
      fin_ovf  = 1'b0;
      acc_nx   = acc_q;
      sum      = i_argA + i_argB;
      diff     = i_argA - i_argB;
      shamt    = i_argB[SW-1:0];

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               op_d = i_oper;
               case (i_oper)
                  OP_ADD: begin
                     sc_res = sum;
                     sc_ovf = (i_argA[M-1] == i_argB[M-1]) && (sum[M-1] != i_argA[M-1]);
                  end
                  OP_SUB: begin
                     sc_res = diff;
                     sc_ovf = (i_argA[M-1] != i_argB[M-1]) && (diff[M-1] != i_argA[M-1]);
                  end
                  OP_AND: sc_res = i_argA & i_argB;
                  OP_OR:  sc_res = i_argA | i_argB;
                  OP_XOR: sc_res = i_argA ^ i_argB;
                  OP_SHL: begin
                     if (shamt == '0) begin
                        sc_res = i_argA;
                     end else begin
                        sc_multi = 1'b1;
                        work_d   = {{M{1'b0}}, i_argA};
                        cnt_d    = CW'(shamt);
                        sovf_d   = 1'b0;
                     end
                  end
                  OP_MUL: begin
                     sc_multi = 1'b1;
                     work_d   = {{M{1'b0}}, i_argA};
                     mplr_d   = i_argB;
                     acc_d    = '0;
                     cnt_d    = CW'(M);
                     sovf_d   = 1'b0;
                  end
                  default: sc_ill = 1'b1;
               endcase

               if (sc_multi) begin
                  state_d = ST_BUSY;
               end else begin
                  state_d  = ST_DONE;
                  result_d = sc_res;
                  status_d = {sc_ill, sc_ovf, sc_res[M-1], sc_res == '0};
               end
            end
         end

         ST_BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_SHL) begin
               // Bit M-1 leaves the result on this step; remember any lost 1.
               work_d  = work_q << 1;
               sovf_d  = sovf_q | work_q[M-1];
               fin_res = work_d[M-1:0];
               fin_ovf = sovf_d;
            end else begin
               acc_nx  = mplr_q[0] ? (acc_q + work_q) : acc_q;
               acc_d   = acc_nx;
               work_d  = work_q << 1;
               mplr_d  = mplr_q >> 1;
               fin_res = acc_nx[M-1:0];
               fin_ovf = |acc_nx[2*M-1:M];
            end
            if (cnt_q == CW'(1)) begin
               state_d  = ST_DONE;
               result_d = fin_res;
               status_d = {1'b0, fin_ovf, fin_res[M-1], fin_res == '0};
            end
         end

         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         work_q   <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sovf_q   <= 1'b0;
         result_q <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         mplr_q   <= mplr_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sovf_q   <= sovf_d;
         result_q <= result_d;
         status_q <= status_d;
      end
   end

   assign o_ready  = (state_q == ST_IDLE);
   assign o_valid  = (state_q == ST_DONE);
   assign o_result = result_q;
   assign o_status = status_q;

endmodule
